// File: rtl/axis_grant_arbiter_pkg.sv
// Shared definitions for the Heartbeat stream arbiter: FSM states, default
// watchdog limit and index-width helper.
package heartbeat_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } arb_state_t;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_grant_arbiter_if.sv
// Request/monitor/grant bundle between the arbiter and the stream controllers.
interface axis_grant_arbiter_if
  import heartbeat_pkg::*;
#(
  parameter int unsigned PORT_COUNT = 4,
  parameter int unsigned STAT_WIDTH = 32
);
  localparam int unsigned IW = idx_width(PORT_COUNT);

  logic [PORT_COUNT-1:0] req;
  logic [PORT_COUNT-1:0] mon_tvalid;
  logic [PORT_COUNT-1:0] mon_tready;
  logic [PORT_COUNT-1:0] mon_tlast;
  logic [PORT_COUNT-1:0] grant;
  logic                  grant_valid;
  logic [IW-1:0]         grant_index;
  logic                  err;
  logic                  timeout;
  logic [STAT_WIDTH-1:0] stat_frames;

  modport slave (
    input  req, mon_tvalid, mon_tready, mon_tlast,
    output grant, grant_valid, grant_index, err, timeout, stat_frames
  );

  modport master (
    output req, mon_tvalid, mon_tready, mon_tlast,
    input  grant, grant_valid, grant_index, err, timeout, stat_frames
  );

endinterface

// File: rtl/axis_grant_arbiter_rr_priority_select.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
module rr_priority_select
  import heartbeat_pkg::*;
#(
  parameter int unsigned PORT_COUNT = 4,
  parameter int unsigned IW         = idx_width(PORT_COUNT)
) (
  input  logic [PORT_COUNT-1:0] req,
  input  logic [IW-1:0]         ptr,
  output logic [PORT_COUNT-1:0] sel,
  output logic [IW-1:0]         idx,
  output logic                  any
);

  logic [IW-1:0] pos;

  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    // Scan offsets 1..N so the current pointer owner comes last.
    for (int unsigned k = 1; k <= PORT_COUNT; k++) begin
      pos = IW'((32'(ptr) + k) % PORT_COUNT);
      if (!any && req[pos]) begin
        any      = 1'b1;
        sel[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/axis_grant_arbiter.sv
// Round-robin grant generator holding each grant until its frame's tlast beat.
// Optional idle-grant watchdog enabled by defining GRANT_TIMEOUT_EN.
module axis_grant_arbiter
  import heartbeat_pkg::*;
#(
  parameter int unsigned PORT_COUNT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned STAT_WIDTH     = 32
) (
  input logic                clk,
  input logic                rst_n,
  axis_grant_arbiter_if.slave bus
);

  localparam int unsigned IW = idx_width(PORT_COUNT);

  arb_state_t            state_q, state_d;
  logic [PORT_COUNT-1:0] grant_q, grant_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [STAT_WIDTH-1:0] stat_q, stat_d;
  logic                  err_q, err_d;
  logic                  timeout_d;

  logic [PORT_COUNT-1:0] beat, done;
  logic [PORT_COUNT-1:0] sel;
  logic [IW-1:0]         sel_idx;
  logic                  sel_any;

  assign beat = bus.mon_tvalid & bus.mon_tready;
  assign done = beat & bus.mon_tlast;

  rr_priority_select #(
    .PORT_COUNT (PORT_COUNT),
    .IW         (IW)
  ) u_select (
    .req (bus.req),
    .ptr (ptr_q),
    .sel (sel),
    .idx (sel_idx),
    .any (sel_any)
  );

`ifdef GRANT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_q, wd_d;
  logic          seen_q, seen_d;
  logic          timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    stat_d    = stat_q;
    err_d     = 1'b0;
    timeout_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
    wd_d      = wd_q;
    seen_d    = seen_q;
`endif
    unique case (state_q)
      IDLE: begin
        err_d = |beat;
        if (sel_any) begin
          grant_d = sel;
          idx_d   = sel_idx;
          state_d = GRANTED;
`ifdef GRANT_TIMEOUT_EN
          wd_d    = '0;
          seen_d  = 1'b0;
`endif
        end
      end
      GRANTED: begin
        err_d = |(beat & ~grant_q);
        if (done[idx_q]) begin
          grant_d = '0;
          idx_d   = '0;
          ptr_d   = idx_q;
          stat_d  = stat_q + STAT_WIDTH'(1);
          state_d = IDLE;
        end
`ifdef GRANT_TIMEOUT_EN
        // Watchdog only covers the wait for the first beat; once started, a frame runs to tlast.
        else if (beat[idx_q]) begin
          seen_d = 1'b1;
        end else if (!seen_q) begin
          if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
            grant_d   = '0;
            idx_d     = '0;
            ptr_d     = idx_q;
            timeout_d = 1'b1;
            state_d   = IDLE;
          end else begin
            wd_d = wd_q + CW'(1);
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= IW'(PORT_COUNT - 1);
      stat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      stat_q  <= stat_d;
      err_q   <= err_d;
    end
  end

`ifdef GRANT_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      seen_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      seen_q    <= seen_d;
      timeout_q <= timeout_d;
    end
  end
  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.grant       = grant_q;
  assign bus.grant_valid = (state_q == GRANTED);
  assign bus.grant_index = idx_q;
  assign bus.err         = err_q;
  assign bus.stat_frames = stat_q;

endmodule

// File: tb/tb_axis_grant_arbiter.sv
// Directed bench for axis_grant_arbiter with an expected-grant scoreboard queue.
module tb_axis_grant_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned SW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  axis_grant_arbiter_if #(.PORT_COUNT(N), .STAT_WIDTH(SW)) bus ();

  axis_grant_arbiter #(
    .PORT_COUNT     (N),
    .TIMEOUT_CYCLES (TO),
    .STAT_WIDTH     (SW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [N-1:0] exp_q[$];
  int unsigned exp_frames = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a grant, then compares it with the oldest scoreboard entry.
  task automatic wait_grant(input string tag);
    int n;
    logic [N-1:0] e;
    n = 0;
    while (bus.grant == '0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd1);
    if (exp_q.size() == 0) begin
      e = '0;
      check({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
    end else begin
      e = exp_q.pop_front();
    end
    check(tag, 64'(bus.grant), 64'(e));
    check({tag, "_valid"}, 64'(bus.grant_valid), 64'd1);
  endtask

  task automatic send_frame(input string tag, input int unsigned lane, input int unsigned nb,
                            input logic [N-1:0] g);
    for (int unsigned b = 0; b < nb; b++) begin
      bus.mon_tvalid       = '0;
      bus.mon_tready       = '0;
      bus.mon_tlast        = '0;
      bus.mon_tvalid[lane] = 1'b1;
      bus.mon_tready[lane] = 1'b1;
      bus.mon_tlast[lane]  = (b == nb - 1);
      @(negedge clk);
      if (b < nb - 1) check({tag, "_hold"}, 64'(bus.grant), 64'(g));
    end
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    bus.mon_tlast  = '0;
    exp_frames++;
    check({tag, "_release"}, 64'(bus.grant), 64'd0);
    check({tag, "_rel_valid"}, 64'(bus.grant_valid), 64'd0);
    check({tag, "_stat"}, 64'(bus.stat_frames), 64'(exp_frames));
    check({tag, "_noerr"}, 64'(bus.err), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, 64'(bus.grant), 64'd0);
    check({tag, "_valid"}, 64'(bus.grant_valid), 64'd0);
    check({tag, "_index"}, 64'(bus.grant_index), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    check({tag, "_stat"}, 64'(bus.stat_frames), 64'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    bus.mon_tlast  = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Test 1: async reset in the middle of a granted frame
    bus.req = 4'b0010;
    exp_q.push_back(4'b0010);
    wait_grant("t1_pre");
    check("t1_pre_index", 64'(bus.grant_index), 64'd1);
    bus.mon_tvalid[1] = 1'b1;
    bus.mon_tready[1] = 1'b1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("t1_async");
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    exp_frames = 0;
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    exp_q.push_back(4'b0001);
    wait_grant("t1_first");
    bus.req = '0;
    send_frame("t1_frame", 0, 1, 4'b0001);

    // Test 2: single request, 3-beat frame
    bus.req = 4'b0001;
    exp_q.push_back(4'b0001);
    wait_grant("t2_grant");
    bus.req = '0;
    send_frame("t2_frame", 0, 3, 4'b0001);

    // Test 3: fresh reset, all requesting, 2-beat frames rotate through every port
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_frames = 0;
    bus.req = 4'b1111;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    for (int unsigned i = 0; i < 5; i++) begin
      wait_grant("t3_rr");
      if (i == 4) bus.req = 4'b0100;
      send_frame("t3_frame", i % N, 2, 4'b0001 << (i % N));
    end

    // Test 4: done on lane 2 with req=0101 wraps to port 0
    exp_q.push_back(4'b0100);
    wait_grant("t4_pre");
    bus.req = 4'b0101;
    send_frame("t4_frame", 2, 2, 4'b0100);
    exp_q.push_back(4'b0001);
    wait_grant("t4_wrap");
    check("t4_index", 64'(bus.grant_index), 64'd0);
    bus.req = 4'b0010;
    send_frame("t4_frame2", 0, 1, 4'b0001);

    // Test 5: beat on a non-granted lane pulses err for one cycle
    exp_q.push_back(4'b0010);
    wait_grant("t5_grant");
    check("t5_index", 64'(bus.grant_index), 64'd1);
    bus.req = '0;
    bus.mon_tvalid[3] = 1'b1;
    bus.mon_tready[3] = 1'b1;
    @(negedge clk);
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    check("t5_err", 64'(bus.err), 64'd1);
    check("t5_grant_kept", 64'(bus.grant), 64'b0010);
    @(negedge clk);
    check("t5_err_clear", 64'(bus.err), 64'd0);
    check("t5_grant_kept2", 64'(bus.grant), 64'b0010);
    send_frame("t5_frame", 1, 1, 4'b0010);
    // A beat while idle is also an error
    bus.mon_tvalid[0] = 1'b1;
    bus.mon_tready[0] = 1'b1;
    @(negedge clk);
    bus.mon_tvalid = '0;
    bus.mon_tready = '0;
    check("t5_idle_err", 64'(bus.err), 64'd1);
    check("t5_idle_grant", 64'(bus.grant), 64'd0);

    // Test 6: granted port never starts its frame
    bus.req = 4'b0011;
    exp_q.push_back(4'b0001);
    wait_grant("t6_grant");
`ifdef GRANT_TIMEOUT_EN
    for (int unsigned c = 1; c < TO; c++) begin
      @(negedge clk);
      check("t6_held", 64'(bus.grant), 64'b0001);
    end
    @(negedge clk);
    check("t6_dropped", 64'(bus.grant), 64'd0);
    check("t6_timeout", 64'(bus.timeout), 64'd1);
    check("t6_stat", 64'(bus.stat_frames), 64'(exp_frames));
    exp_q.push_back(4'b0010);
    wait_grant("t6_next");
    check("t6_timeout_clear", 64'(bus.timeout), 64'd0);
    bus.req = '0;
    send_frame("t6_frame", 1, 1, 4'b0010);
`else
    repeat (100) @(negedge clk);
    check("t6_held100", 64'(bus.grant), 64'b0001);
    check("t6_no_timeout", 64'(bus.timeout), 64'd0);
    bus.req = '0;
    send_frame("t6_frame", 0, 1, 4'b0001);
`endif

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
